axis_pipe_skid: RTL and testbench
=================================

Name: axis_pipe_skid

Overview:
- Parametrised AXI4-Stream register slice for the decompression datapath, sitting between the DMA c2s/s2c stream ports and the decompression core.
- Adds true per-beat ready/valid backpressure with a skid register per stage, so full throughput is kept with registered tready.
- Depth (stage count) and data width are configurable.
- Provides occupancy and output packet-count status.

Parameters:
- DATA_W, 256, tdata width in bits; multiple of 8, range 8..1024
- KEEP_W, DATA_W/8, tkeep width; derived, do not override
- STAGES, 1, number of cascaded skid stages; legal range 1..8
- CNT_W, 32, width of the output packet counter

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  DATA_W  upstream data
- s_axis_tkeep  in  KEEP_W  upstream byte enables
- s_axis_tlast  in  1  upstream end of packet
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  registered ready to upstream
- m_axis_tdata  out  DATA_W  downstream data
- m_axis_tkeep  out  KEEP_W  downstream byte enables
- m_axis_tlast  out  1  downstream end of packet
- m_axis_tvalid  out  1  downstream valid
- m_axis_tready  in  1  downstream ready
- occupancy  out  $clog2(2*STAGES+1)  beats currently held in all stages
- pkt_count  out  CNT_W  count of tlast beats accepted at the master side

Behaviour:
- Transfer rule: a beat moves on an interface only when tvalid and tready are both high on a rising aclk edge.
- Beats are never dropped, duplicated or reordered. Ordering and the {tdata, tkeep, tlast} payload are preserved bit-exactly.
- Each stage has a main register (M) and a skid register (K), each with its own valid flag. Its states are:
  - EMPTY: M and K both invalid.
  - ONE: M valid, K invalid.
  - FULL: M and K both valid.
- Stage transitions, with in = upstream transfer and out = downstream transfer:
  - EMPTY + in -> ONE.
  - ONE + in without out -> FULL; the incoming beat goes to K.
  - ONE + in + out -> ONE; M is reloaded with the incoming beat.
  - ONE + out without in -> EMPTY.
  - FULL + out -> ONE; K moves to M.
  - FULL + in cannot occur, because ready is low in FULL.
- Stage tready is a register equal to "next state is not FULL". No combinational path runs from m_axis_tready to s_axis_tready.
- Stage output valid is the M valid flag, driven directly from a flop.
- Latency: STAGES cycles from s-side accept to m_axis_tvalid when downstream is ready.
- Throughput: 1 beat/cycle sustained with m_axis_tready held high.
- Capacity: 2*STAGES beats buffered when downstream stalls. s_axis_tready falls the cycle after the last free slot is filled.
- Payload registers (M, K) have no reset; only the valid flags and ready are reset. When M is invalid, the visible data is don't-care.
- occupancy:
  - Registered sum of all valid flags.
  - Updates by +1 on an s-side transfer, -1 on an m-side transfer, and by 0 when both happen in the same cycle.
- pkt_count:
  - Increments by 1 on every m-side transfer with m_axis_tlast = 1.
  - Wraps modulo 2^CNT_W with no saturation.
  - Holds otherwise.
- Reset (async assert, release synchronous to aclk):
  - All valid flags are 0, m_axis_tvalid = 0, s_axis_tready = 0, occupancy = 0, pkt_count = 0.
  - s_axis_tready rises on the first aclk edge after areset deasserts.
- Reset asserted mid-packet discards all buffered beats immediately; there is no tlast fixup.
- tvalid held with tready low: the s-side may change or withdraw the beat (AXI violation on the source side). The block samples only on transfer and needs no protection.

Decomposition:
- Package axis_pkg holds:
  - the beat struct type {tdata, tkeep, tlast} parametrised by DATA_W;
  - the stage-state encoding constants ST_EMPTY, ST_ONE, ST_FULL;
  - the occupancy width function.
- Sub-module axis_skid_stage implements one M/K stage.
- The top-level axis_pipe_skid contains:
  - a generate loop chaining STAGES instances;
  - the occupancy counter;
  - the pkt_count counter.

Test Plan:
- Reset check: assert areset mid-stream with 3 beats buffered. Expect m_axis_tvalid = 0, occupancy = 0 and pkt_count = 0 immediately. s_axis_tready must be 0 during reset and 1 on the first edge after release.
- Streaming, STAGES = 2, ready held high: drive 16 beats with tdata = index, tkeep = all ones and tlast on beat 15. Expect first m_axis_tvalid 2 cycles after the first accept, 16 back-to-back output beats in order, then pkt_count = 1.
- Full stall, STAGES = 2, m_axis_tready = 0: drive continuously. Expect exactly 4 beats accepted, s_axis_tready = 0 from the following cycle, and occupancy = 4. After releasing ready, expect beats 0..3 out in order and s_axis_tready back to 1 within 1 cycle of the first output transfer.
- Random backpressure: 10,000 beats with random tkeep, random tlast (about 1 in 8) and random tvalid/tready at 50%. The scoreboard must show zero loss, zero reorder and a pkt_count equal to the number of tlast beats sent. occupancy must never exceed 2*STAGES.
- Simultaneous in/out in state ONE, with ready toggling every cycle: occupancy stays constant on cycles where both transfers occur, and data order is preserved.
- Counter wrap, CNT_W = 4: send 17 single-beat packets. Expect pkt_count = 1 after the 17th.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream skid-buffer pipeline.
// The beat struct is declared once in this package, sized for the widest legal
// tdata (1024 bits). Modules use a narrower struct of the same layout that
// matches their own DATA_W, and they size it with beat_width().
package axis_pkg;

    // Widest tdata the pipeline accepts; this sizes the reference beat type.
    localparam int DATA_W_MAX = 1024;

    // Per-stage occupancy state. Bit 0 is the M valid flag and bit 1 is the
    // K valid flag. Because of this encoding, the stage's output valid is a
    // single flop. 2'b10 (K without M) is unreachable and recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_t;

    // Reference beat layout {tdata, tkeep, tlast} at the maximum width.
    typedef struct packed {
        logic [DATA_W_MAX-1:0]   tdata;
        logic [DATA_W_MAX/8-1:0] tkeep;
        logic                    tlast;
    } beat_max_t;

    // Width of the occupancy counter. It must represent 0..2*stages.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Bits in one packed beat {tdata, tkeep, tlast} for a given tdata width.
    function automatic int beat_width(input int data_w);
        return data_w + (data_w / 8) + 1;
    endfunction

endpackage

// File: rtl/axis_pipe_skid_stage.sv
// One register-slice stage. It has a main register (M) and a skid register (K).
// Ready toward the source is a flop that holds "next state is not FULL", so no
// combinational path runs from out_ready to in_ready. The beat that arrives on
// the same edge that ready drops is caught in K.
module axis_skid_stage
    import axis_pkg::*;
#(
    parameter int BEAT_W = 289
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    stage_state_t      state_r;
    stage_state_t      state_nxt_s;
    logic              ready_r;
    logic [BEAT_W-1:0] m_data_r;
    logic [BEAT_W-1:0] k_data_r;
    logic              m_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              load_m_in_s;
    logic              load_m_k_s;
    logic              load_k_s;

    assign m_valid_s  = state_r[0];
    assign in_fire_s  = in_valid & ready_r;
    assign out_fire_s = m_valid_s & out_ready;

    // Next-state and payload-steering decode for the M/K pair.
    always_comb begin
        state_nxt_s = state_r;
        load_m_in_s = 1'b0;
        load_m_k_s  = 1'b0;
        load_k_s    = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_nxt_s = ST_ONE;
                    load_m_in_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    // Pass-through: the new beat replaces the one that just left.
                    state_nxt_s = ST_ONE;
                    load_m_in_s = 1'b1;
                end else if (in_fire_s) begin
                    state_nxt_s = ST_FULL;
                    load_k_s    = 1'b1;
                end else if (out_fire_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                // Ready is low in FULL, so only the drain path can fire.
                if (out_fire_s) begin
                    state_nxt_s = ST_ONE;
                    load_m_k_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State (valid flags) and registered ready. These are the only reset flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    // Payload registers. They are not reset, because contents are qualified by the valid flags.
    always_ff @(posedge clk) begin
        if (load_m_in_s) begin
            m_data_r <= in_data;
        end else if (load_m_k_s) begin
            m_data_r <= k_data_r;
        end else begin
            m_data_r <= m_data_r;
        end
        if (load_k_s) begin
            k_data_r <= in_data;
        end else begin
            k_data_r <= k_data_r;
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = m_valid_s;
    assign out_data  = m_data_r;

endmodule

// File: rtl/axis_pipe_skid.sv
// AXI4-Stream register slice: STAGES cascaded M/K skid stages, plus the
// buffered-beat occupancy and the count of tlast beats delivered downstream.
module axis_pipe_skid
    import axis_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32,
    localparam int OCC_W = occ_width(STAGES)
)
(
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  pkt_count
);

    // Same field order as axis_pkg::beat_max_t, sized for this instance.
    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
    } beat_t;

    localparam int BEAT_W = beat_width(DATA_W);

    beat_t             s_beat_s;
    beat_t             m_beat_s;
    logic [BEAT_W-1:0] link_data_s  [0:STAGES];
    logic              link_valid_s [0:STAGES];
    logic              link_ready_s [0:STAGES];
    logic              s_fire_s;
    logic              m_fire_s;
    logic [OCC_W-1:0]  occ_r;
    logic [CNT_W-1:0]  pkt_r;

    assign s_beat_s.tdata = s_axis_tdata;
    assign s_beat_s.tkeep = s_axis_tkeep;
    assign s_beat_s.tlast = s_axis_tlast;

    assign link_data_s[0]       = s_beat_s;
    assign link_valid_s[0]      = s_axis_tvalid;
    assign link_ready_s[STAGES] = m_axis_tready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        axis_skid_stage #(
            .BEAT_W (BEAT_W)
        ) u_stage (
            .clk       (aclk),
            .rst       (areset),
            .in_data   (link_data_s[i]),
            .in_valid  (link_valid_s[i]),
            .in_ready  (link_ready_s[i]),
            .out_data  (link_data_s[i+1]),
            .out_valid (link_valid_s[i+1]),
            .out_ready (link_ready_s[i+1])
        );
    end

    assign m_beat_s      = link_data_s[STAGES];
    assign m_axis_tdata  = m_beat_s.tdata;
    assign m_axis_tkeep  = m_beat_s.tkeep;
    assign m_axis_tlast  = m_beat_s.tlast;
    assign m_axis_tvalid = link_valid_s[STAGES];
    assign s_axis_tready = link_ready_s[0];

    assign s_fire_s = s_axis_tvalid & s_axis_tready;
    assign m_fire_s = m_axis_tvalid & m_axis_tready;

    // Occupancy tracks the sum of valid flags. Internal stage-to-stage moves leave it unchanged.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            case ({s_fire_s, m_fire_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Count end-of-packet beats delivered downstream. The counter wraps freely.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_r <= {CNT_W{1'b0}};
        end else if (m_fire_s && m_axis_tlast) begin
            pkt_r <= pkt_r + CNT_W'(1);
        end else begin
            pkt_r <= pkt_r;
        end
    end

    assign occupancy = occ_r;
    assign pkt_count = pkt_r;

endmodule

// File: tb/tb_axis_pipe_skid.sv
// Directed bench for axis_pipe_skid (STAGES=2, DATA_W=32, CNT_W=4).
module tb_axis_pipe_skid;

    localparam int DW = 32;
    localparam int KW = 4;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [2:0]    occupancy;
    logic [3:0]    pkt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pkt  = 0;

    axis_pipe_skid #(
        .DATA_W (DW),
        .STAGES (2),
        .CNT_W  (4)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .occupancy     (occupancy),
        .pkt_count     (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        areset = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        s_tdata = 32'h0; s_tkeep = 4'h0; s_tlast = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (s_tready !== 1'b0) begin $display("FAIL reset_tready: got %b want 0", s_tready); n_fail++; end
        n_checks++; if (m_tvalid !== 1'b0) begin $display("FAIL reset_mvalid: got %b want 0", m_tvalid); n_fail++; end
        n_checks++; if (occupancy !== 3'd0) begin $display("FAIL reset_occ: got %0d want 0", occupancy); n_fail++; end
        n_checks++; if (pkt_count !== 4'd0) begin $display("FAIL reset_pkt: got %0d want 0", pkt_count); n_fail++; end
        areset = 1'b0;
        #1;
        n_checks++; if (s_tready !== 1'b0) begin $display("FAIL release_tready_early: got %b want 0", s_tready); n_fail++; end
        tick;
        n_checks++; if (s_tready !== 1'b1) begin $display("FAIL release_tready_edge: got %b want 1", s_tready); n_fail++; end
        n_checks++; if (m_tvalid !== 1'b0) begin $display("FAIL release_mvalid: got %b want 0", m_tvalid); n_fail++; end
    endtask

    task automatic test_streaming;
        int sent, rcv, first_acc, first_mv, gaps;
        logic exp_last;
        sent = 0; rcv = 0; first_acc = -1; first_mv = -1; gaps = 0;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 60 && rcv < 16; cyc++) begin
            if (sent < 16) begin
                s_tvalid = 1'b1; s_tdata = 32'(sent); s_tkeep = 4'hF; s_tlast = (sent == 15);
            end else begin
                s_tvalid = 1'b0;
            end
            @(negedge aclk);
            if (s_tvalid && s_tready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            if (m_tvalid) begin
                if (first_mv < 0) first_mv = cyc;
                exp_last = (rcv == 15);
                n_checks++;
                if ({m_tdata, m_tkeep, m_tlast} !== {32'(rcv), 4'hF, exp_last}) begin
                    $display("FAIL stream_beat%0d: got %h/%h/%b want %h/f/%b", rcv, m_tdata, m_tkeep, m_tlast, rcv, exp_last);
                    n_fail++;
                end
                rcv++;
            end else if (first_mv >= 0) begin
                gaps++;
            end
            tick;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_pkt = exp_pkt + 1;
        n_checks++; if (first_mv - first_acc != 2) begin $display("FAIL stream_latency: got %0d want 2", first_mv - first_acc); n_fail++; end
        n_checks++; if (rcv != 16) begin $display("FAIL stream_count: got %0d want 16", rcv); n_fail++; end
        n_checks++; if (gaps != 0) begin $display("FAIL stream_gaps: got %0d want 0", gaps); n_fail++; end
        n_checks++; if (pkt_count !== 4'd1) begin $display("FAIL stream_pkt: got %0d want 1", pkt_count); n_fail++; end
        n_checks++; if (occupancy !== 3'd0) begin $display("FAIL stream_occ: got %0d want 0", occupancy); n_fail++; end
    endtask

    task automatic test_full_stall;
        int sent, rcv, fire_cyc, rise_cyc;
        sent = 0; m_tready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            s_tvalid = 1'b1; s_tdata = 32'(100 + sent); s_tkeep = 4'h3; s_tlast = 1'b0;
            @(negedge aclk);
            if (cyc == 4) begin
                n_checks++; if (s_tready !== 1'b0) begin $display("FAIL stall_ready_drop: got %b want 0", s_tready); n_fail++; end
            end
            if (s_tvalid && s_tready) sent++;
            tick;
        end
        s_tvalid = 1'b0;
        n_checks++; if (sent != 4) begin $display("FAIL stall_accepted: got %0d want 4", sent); n_fail++; end
        n_checks++; if (occupancy !== 3'd4) begin $display("FAIL stall_occ: got %0d want 4", occupancy); n_fail++; end
        n_checks++; if (m_tvalid !== 1'b1) begin $display("FAIL stall_mvalid: got %b want 1", m_tvalid); n_fail++; end
        m_tready = 1'b1; rcv = 0; fire_cyc = -1; rise_cyc = -1;
        for (int cyc = 0; cyc < 20 && (rcv < 4 || rise_cyc < 0); cyc++) begin
            @(negedge aclk);
            if (s_tready && rise_cyc < 0) rise_cyc = cyc;
            if (m_tvalid) begin
                if (fire_cyc < 0) fire_cyc = cyc;
                n_checks++;
                if (m_tdata !== 32'(100 + rcv)) begin $display("FAIL stall_drain%0d: got %0d want %0d", rcv, m_tdata, 100 + rcv); n_fail++; end
                rcv++;
            end
            tick;
        end
        n_checks++; if (rcv != 4) begin $display("FAIL stall_drain_count: got %0d want 4", rcv); n_fail++; end
        // ready is seen in cycle rise_cyc, so it rose on the edge ending cycle rise_cyc-1
        n_checks++;
        if (rise_cyc < 0 || fire_cyc < 0 || (rise_cyc - 1) - fire_cyc > 1) begin
            $display("FAIL stall_ready_recover: got %0d edges want <=1", (rise_cyc - 1) - fire_cyc); n_fail++;
        end
    endtask

    task automatic test_simultaneous;
        int sent, rcv, occ_model, occ_before, both;
        bit prev_both, sf, mf;
        sent = 0; rcv = 0; occ_model = 0; both = 0; prev_both = 1'b0; occ_before = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            m_tready = cyc[0];
            s_tvalid = (cyc == 0) ? 1'b1 : cyc[0];
            s_tdata = 32'h5000 + 32'(sent); s_tkeep = 4'hA; s_tlast = 1'b0;
            @(negedge aclk);
            n_checks++; if (occupancy !== 3'(occ_model)) begin $display("FAIL simul_occ_c%0d: got %0d want %0d", cyc, occupancy, occ_model); n_fail++; end
            if (prev_both) begin
                n_checks++; if (occupancy !== 3'(occ_before)) begin $display("FAIL simul_occ_hold_c%0d: got %0d want %0d", cyc, occupancy, occ_before); n_fail++; end
            end
            sf = s_tvalid && s_tready;
            mf = m_tvalid && m_tready;
            if (mf) begin
                n_checks++; if (m_tdata !== 32'h5000 + 32'(rcv)) begin $display("FAIL simul_order%0d: got %h want %h", rcv, m_tdata, 32'h5000 + rcv); n_fail++; end
                rcv++;
            end
            if (sf) sent++;
            prev_both = sf && mf;
            if (prev_both) begin both++; occ_before = occ_model; end
            occ_model = occ_model + int'(sf) - int'(mf);
            tick;
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        for (int cyc = 0; cyc < 12 && rcv < sent; cyc++) begin
            @(negedge aclk);
            if (m_tvalid) begin
                n_checks++; if (m_tdata !== 32'h5000 + 32'(rcv)) begin $display("FAIL simul_drain%0d: got %h want %h", rcv, m_tdata, 32'h5000 + rcv); n_fail++; end
                rcv++;
            end
            tick;
        end
        n_checks++; if (both == 0) begin $display("FAIL simul_no_overlap: got 0 want >0"); n_fail++; end
        n_checks++; if (rcv != sent) begin $display("FAIL simul_count: got %0d want %0d", rcv, sent); n_fail++; end
    endtask

    task automatic test_random;
        logic [36:0] sbq[$];
        logic [36:0] exp_beat;
        int sent, rcv, occ_model;
        bit sf, mf;
        sent = 0; rcv = 0; occ_model = 0;
        for (int cyc = 0; cyc < 60000 && rcv < 10000; cyc++) begin
            if (sent < 10000 && $urandom_range(1, 0) == 1) begin
                s_tvalid = 1'b1; s_tdata = $urandom; s_tkeep = 4'($urandom);
                s_tlast = ($urandom_range(7, 0) == 0);
            end else begin
                s_tvalid = 1'b0;
            end
            m_tready = ($urandom_range(1, 0) == 1);
            @(negedge aclk);
            n_checks++; if (occupancy !== 3'(occ_model) || occupancy > 3'd4) begin $display("FAIL rand_occ_c%0d: got %0d want %0d", cyc, occupancy, occ_model); n_fail++; end
            sf = s_tvalid && s_tready;
            mf = m_tvalid && m_tready;
            if (sf) begin sbq.push_back({s_tdata, s_tkeep, s_tlast}); sent++; end
            if (mf) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    $display("FAIL rand_extra_beat: got %h want none", {m_tdata, m_tkeep, m_tlast}); n_fail++;
                end else begin
                    exp_beat = sbq.pop_front();
                    if ({m_tdata, m_tkeep, m_tlast} !== exp_beat) begin
                        $display("FAIL rand_beat%0d: got %h want %h", rcv, {m_tdata, m_tkeep, m_tlast}, exp_beat); n_fail++;
                    end
                    if (exp_beat[0]) exp_pkt = exp_pkt + 1;
                end
                rcv++;
            end
            occ_model = occ_model + int'(sf) - int'(mf);
            tick;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n_checks++; if (rcv != 10000) begin $display("FAIL rand_count: got %0d want 10000", rcv); n_fail++; end
        n_checks++; if (sbq.size() != 0) begin $display("FAIL rand_leftover: got %0d want 0", sbq.size()); n_fail++; end
        n_checks++; if (pkt_count !== 4'(exp_pkt)) begin $display("FAIL rand_pkt: got %0d want %0d", pkt_count, 4'(exp_pkt)); n_fail++; end
    endtask

    task automatic test_reset_midstream;
        int sent;
        // one complete packet first so that pkt_count is nonzero before reset
        m_tready = 1'b1; sent = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            s_tvalid = (sent == 0); s_tdata = 32'hAB; s_tkeep = 4'hF; s_tlast = 1'b1;
            @(negedge aclk);
            if (s_tvalid && s_tready) sent++;
            tick;
        end
        exp_pkt = exp_pkt + 1;
        n_checks++; if (pkt_count !== 4'(exp_pkt)) begin $display("FAIL mid_pre_pkt: got %0d want %0d", pkt_count, 4'(exp_pkt)); n_fail++; end
        m_tready = 1'b0; sent = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            s_tvalid = 1'b1; s_tdata = 32'(200 + cyc); s_tkeep = 4'h1; s_tlast = (cyc == 1);
            @(negedge aclk);
            if (s_tvalid && s_tready) sent++;
            tick;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n_checks++; if (occupancy !== 3'd3 || sent != 3) begin $display("FAIL mid_buffered: got %0d want 3", occupancy); n_fail++; end
        #2 areset = 1'b1;
        #1;
        exp_pkt = 0;
        n_checks++; if (m_tvalid !== 1'b0) begin $display("FAIL mid_mvalid: got %b want 0", m_tvalid); n_fail++; end
        n_checks++; if (occupancy !== 3'd0) begin $display("FAIL mid_occ: got %0d want 0", occupancy); n_fail++; end
        n_checks++; if (pkt_count !== 4'd0) begin $display("FAIL mid_pkt: got %0d want 0", pkt_count); n_fail++; end
        n_checks++; if (s_tready !== 1'b0) begin $display("FAIL mid_tready: got %b want 0", s_tready); n_fail++; end
        @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (s_tready !== 1'b0) begin $display("FAIL mid_tready_held: got %b want 0", s_tready); n_fail++; end
        areset = 1'b0;
        tick;
        n_checks++; if (s_tready !== 1'b1) begin $display("FAIL mid_tready_release: got %b want 1", s_tready); n_fail++; end
        n_checks++; if (m_tvalid !== 1'b0) begin $display("FAIL mid_mvalid_release: got %b want 0", m_tvalid); n_fail++; end
    endtask

    task automatic test_counter_wrap;
        int sent, rcv;
        sent = 0; rcv = 0; m_tready = 1'b1;
        for (int cyc = 0; cyc < 100 && rcv < 17; cyc++) begin
            if (sent < 17) begin
                s_tvalid = 1'b1; s_tdata = 32'(300 + sent); s_tkeep = 4'hF; s_tlast = 1'b1;
            end else begin
                s_tvalid = 1'b0;
            end
            @(negedge aclk);
            if (s_tvalid && s_tready) sent++;
            if (m_tvalid) begin
                n_checks++; if (m_tdata !== 32'(300 + rcv) || m_tlast !== 1'b1) begin $display("FAIL wrap_beat%0d: got %0d/%b want %0d/1", rcv, m_tdata, m_tlast, 300 + rcv); n_fail++; end
                rcv++;
            end
            tick;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n_checks++; if (rcv != 17) begin $display("FAIL wrap_count: got %0d want 17", rcv); n_fail++; end
        n_checks++; if (pkt_count !== 4'd1) begin $display("FAIL wrap_pkt: got %0d want 1", pkt_count); n_fail++; end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_full_stall;
        test_simultaneous;
        test_random;
        test_reset_midstream;
        test_counter_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
